// File: rtl/sda_link_arbiter.sv
// Round-robin sequencer sharing one 4-bit SDA serializer among N requesters.
// A per-state watchdog traps a serializer that never starts or never finishes.
module sda_link_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  parameter int TW      = 8
) (
  input  logic           sclk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [4*N-1:0] data_in,
  output logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [3:0]     ser_data,
  output logic           ser_start,
  input  logic           ser_busy,
  output logic           err,
  input  logic           err_clr,
  output logic [7:0]     xfer_cnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    ERR       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [3:0]    ser_data_q, ser_data_d;
  logic          ser_start_q, ser_start_d;
  logic          err_q, err_d;
  logic [7:0]    xfer_cnt_q, xfer_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] win_q, win_d;

  logic [IW-1:0] cand_s;
  logic [IW-1:0] pick_s;
  logic [3:0]    pick_data_s;

  // Scan from the farthest slot back toward last+1 so the nearest requester wins.
  always_comb begin
    pick_s = last_q;
    cand_s = last_q;
    for (int k = N; k >= 1; k--) begin
      cand_s = IW'((int'(last_q) + k) % N);
      pick_s = req[cand_s] ? cand_s : pick_s;
    end
  end

  // Nibble of the arbitration winner.
  always_comb begin
    pick_data_s = 4'h0;
    for (int i = 0; i < N; i++) begin
      pick_data_s = (IW'(i) == pick_s) ? data_in[4*i +: 4] : pick_data_s;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = {N{1'b0}};
    ser_data_d  = ser_data_q;
    ser_start_d = 1'b0;
    err_d       = err_q;
    xfer_cnt_d  = xfer_cnt_q;
    timer_d     = timer_q;
    last_d      = last_q;
    win_d       = win_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d       = pick_s;
          gnt_d       = ONE_HOT0 << pick_s;
          ser_data_d  = pick_data_s;
          ser_start_d = 1'b1;
          timer_d     = {TW{1'b0}};
          state_d     = WAIT_BUSY;
        end else begin
          gnt_d = {N{1'b0}};
        end
      end
      WAIT_BUSY: begin
        if (ser_busy) begin
          timer_d = {TW{1'b0}};
          state_d = WAIT_DONE;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          gnt_d   = {N{1'b0}};
          last_d  = win_q;
          state_d = ERR;
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      WAIT_DONE: begin
        // Completion is checked first so a busy fall on the timeout cycle still finishes.
        if (!ser_busy) begin
          done_d     = gnt_q;
          gnt_d      = {N{1'b0}};
          last_d     = win_q;
          xfer_cnt_d = xfer_cnt_q + 8'd1;
          state_d    = IDLE;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          gnt_d   = {N{1'b0}};
          last_d  = win_q;
          state_d = ERR;
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      ERR: begin
        gnt_d = {N{1'b0}};
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        gnt_d   = {N{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= {N{1'b0}};
      done_q      <= {N{1'b0}};
      ser_data_q  <= 4'h0;
      ser_start_q <= 1'b0;
      err_q       <= 1'b0;
      xfer_cnt_q  <= 8'd0;
      timer_q     <= {TW{1'b0}};
      last_q      <= LAST_RST;
      win_q       <= {IW{1'b0}};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      ser_data_q  <= ser_data_d;
      ser_start_q <= ser_start_d;
      err_q       <= err_d;
      xfer_cnt_q  <= xfer_cnt_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      win_q       <= win_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign ser_data  = ser_data_q;
  assign ser_start = ser_start_q;
  assign err       = err_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_sda_link_arbiter.sv
// Bench for sda_link_arbiter: table of directed transfers, watchdog/reset sequences,
// then random transfers predicted by a transaction-level round-robin model.
module tb_sda_link_arbiter;
  logic        sclk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  done;
  logic [3:0]  gnt;
  logic [3:0]  ser_data;
  logic        ser_start;
  logic        ser_busy;
  logic        err;
  logic        err_clr;
  logic [7:0]  xfer_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_last;
  logic [7:0]  m_cnt;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  r;
    int          dly;
    int          len;
    bit          drop;
    int          w;
    logic [3:0]  d;
  } vec_t;

  vec_t tbl [13];

  sda_link_arbiter #(.N(4), .TIMEOUT(64), .TW(8)) dut (
    .sclk(sclk), .rst(rst), .req(req), .data_in(data_in), .done(done), .gnt(gnt),
    .ser_data(ser_data), .ser_start(ser_start), .ser_busy(ser_busy), .err(err),
    .err_clr(err_clr), .xfer_cnt(xfer_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Round robin by definition: first requester found walking last+1, last+2, ... mod 4.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (((r >> idx) & 4'b0001) != 4'b0000) return idx;
    end
    return -1;
  endfunction

  task automatic do_xfer(input logic [15:0] dat, input logic [3:0] r, input int dly, input int len,
                         input bit drop, input int w, input logic [3:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    data_in = dat;
    req = r;
    ser_busy = 1'b0;
    tick();
    check("grant", 32'(gnt), 32'(oh));
    check("start_pulse", 32'(ser_start), 32'd1);
    check("ser_data", 32'(ser_data), 32'(d));
    check("done_quiet", 32'(done), 32'd0);
    data_in = ~dat;
    for (int i = 0; i < dly; i++) begin
      tick();
      check("start_once", 32'(ser_start), 32'd0);
      check("gnt_wait_busy", 32'(gnt), 32'(oh));
    end
    ser_busy = 1'b1;
    if (drop) req = r & ~oh;
    for (int i = 0; i < len; i++) begin
      tick();
      check("gnt_hold", 32'(gnt), 32'(oh));
      check("no_early_done", 32'(done), 32'd0);
    end
    check("start_low", 32'(ser_start), 32'd0);
    check("data_latched", 32'(ser_data), 32'(d));
    ser_busy = 1'b0;
    tick();
    m_cnt = m_cnt + 8'd1;
    check("done", 32'(done), 32'(oh));
    check("gnt_release", 32'(gnt), 32'd0);
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    check("err_quiet", 32'(err), 32'd0);
    m_last = w;
  endtask

  task automatic do_err(input logic [3:0] r, input int w, input bit in_done);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    data_in = 16'h4321;
    req = r;
    ser_busy = 1'b0;
    tick();
    check("err_grant", 32'(gnt), 32'(oh));
    if (in_done) ser_busy = 1'b1;
    for (int i = 0; i < (in_done ? 64 : 63); i++) begin
      tick();
      check("err_early", 32'(err), 32'd0);
      check("err_wait_gnt", 32'(gnt), 32'(oh));
    end
    tick();
    check("err_set", 32'(err), 32'd1);
    check("err_gnt", 32'(gnt), 32'd0);
    check("err_no_done", 32'(done), 32'd0);
    ser_busy = 1'b0;
    req = 4'b0000;
    tick();
    check("err_sticky", 32'(err), 32'd1);
    check("err_no_done2", 32'(done), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clear", 32'(err), 32'd0);
    m_last = w;
  endtask

  initial begin
    logic [3:0]  r;
    logic [15:0] dat;
    logic [3:0]  d;
    logic [3:0]  oh;
    int          w;
    int          dly;
    int          len;
    bit          drop;

    // Directed vectors; requester i owns nibble i of data (default 1,2,3,4).
    tbl[0]  = '{16'h4321, 4'b1111, 0,  1,  1'b0, 0, 4'h1};
    tbl[1]  = '{16'h4321, 4'b1111, 1,  2,  1'b0, 1, 4'h2};
    tbl[2]  = '{16'h4321, 4'b1111, 2,  3,  1'b0, 2, 4'h3};
    tbl[3]  = '{16'h4321, 4'b1111, 5,  4,  1'b0, 3, 4'h4};
    tbl[4]  = '{16'h4321, 4'b1111, 0,  1,  1'b0, 0, 4'h1};
    tbl[5]  = '{16'h432A, 4'b0001, 3,  10, 1'b0, 0, 4'hA};
    tbl[6]  = '{16'h4321, 4'b0100, 1,  3,  1'b1, 2, 4'h3};
    tbl[7]  = '{16'h4321, 4'b1001, 0,  2,  1'b0, 3, 4'h4};
    tbl[8]  = '{16'h4321, 4'b1001, 0,  2,  1'b0, 0, 4'h1};
    tbl[9]  = '{16'h4321, 4'b0110, 2,  2,  1'b0, 1, 4'h2};
    tbl[10] = '{16'h4321, 4'b0001, 63, 1,  1'b0, 0, 4'h1};
    tbl[11] = '{16'h4321, 4'b1010, 0,  64, 1'b0, 1, 4'h2};
    tbl[12] = '{16'h9CB5, 4'b1100, 1,  1,  1'b0, 2, 4'hC};

    rst = 1'b0;
    req = 4'b0000;
    data_in = 16'h0000;
    ser_busy = 1'b0;
    err_clr = 1'b0;
    m_last = 3;
    m_cnt = 8'd0;
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_start", 32'(ser_start), 32'd0);
    check("rst_data", 32'(ser_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_xfer", 32'(xfer_cnt), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_xfer(tbl[i].data, tbl[i].r, tbl[i].dly, tbl[i].len, tbl[i].drop, tbl[i].w, tbl[i].d);
    end

    // Watchdog in WAIT_BUSY, then the failed requester (3) is skipped.
    do_err(4'b1111, 3, 1'b0);
    do_xfer(16'h4321, 4'b1111, 0, 1, 1'b0, 0, 4'h1);
    // Watchdog in WAIT_DONE, then requester 1 is skipped in favour of 0.
    do_err(4'b1111, 1, 1'b1);
    do_xfer(16'h4321, 4'b0011, 0, 1, 1'b0, 0, 4'h1);

    // Reset while in WAIT_DONE.
    data_in = 16'h4321;
    req = 4'b1111;
    ser_busy = 1'b0;
    tick();
    oh = 4'b0001 << rr_pick(4'b1111, m_last);
    check("pre_rst_grant", 32'(gnt), 32'(oh));
    ser_busy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_start", 32'(ser_start), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_xfer", 32'(xfer_cnt), 32'd0);
    check("midrst_data", 32'(ser_data), 32'd0);
    tick();
    check("midrst_done_held", 32'(done), 32'd0);
    rst = 1'b1;
    ser_busy = 1'b0;
    m_last = 3;
    m_cnt = 8'd0;
    do_xfer(16'h4321, 4'b1111, 0, 2, 1'b0, 0, 4'h1);

    // Random traffic: 255 more transfers bring the count to 256.
    for (int t = 0; t < 255; t++) begin
      r = 4'($urandom_range(1, 15));
      dat = 16'($urandom);
      w = rr_pick(r, m_last);
      d = 4'((dat >> (4 * w)) & 16'h000F);
      dly = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 4));
      drop = 1'($urandom_range(0, 1));
      do_xfer(dat, r, dly, len, drop, w, d);
    end
    check("xfer_wrap", 32'(xfer_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
